sdram_cmd_monitor: RTL and testbench

//  Passive decoder/checker on the SDRAM command bus driven by the arbiter
//  (cs_n/ras_n/cas_n/we_n/ba/addr). Decodes each command, tracks per-bank open

---
 rtl/sdram_cmd_monitor.sv | 256 +++++++++++++++++++++++++
 tb/tb_sdram_cmd_monitor.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command-bus monitor: decodes commands, tracks open banks,
// counts operations and flags sticky protocol/timing violations (2-cycle latency).
module sdram_cmd_monitor #(
  parameter int unsigned T_RCD     = 2,
  parameter int unsigned T_RP      = 2,
  parameter int unsigned T_RFC     = 7,
  parameter int unsigned T_MRD     = 3,
  parameter int unsigned T_REF_MAX = 781,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdram_cs_n,
  input  logic             sdram_ras_n,
  input  logic             sdram_cas_n,
  input  logic             sdram_we_n,
  input  logic [1:0]       sdram_ba,
  input  logic [12:0]      sdram_addr,
  input  logic             err_clr,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic [1:0]       cmd_ba,
  output logic [3:0]       bank_open,
  output logic [7:0]       err_flags,
  output logic             err_pulse,
  output logic [CNT_W-1:0] aref_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_AREF = 3'd5,
    CMD_MRS  = 3'd6,
    CMD_BST  = 3'd7
  } cmd_e;

  typedef enum logic {
    REF_IDLE,
    REF_ARMED
  } ref_state_e;

  localparam int unsigned RCD_W   = $clog2(T_RCD + 1);
  localparam int unsigned RP_W    = $clog2(T_RP + 1);
  localparam int unsigned GLB_MAX = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int unsigned GLB_W   = $clog2(GLB_MAX + 1);
  localparam int unsigned REF_W   = $clog2(T_REF_MAX + 2);

  localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(T_RCD - 1);
  localparam logic [RP_W-1:0]  RP_LOAD  = RP_W'(T_RP - 1);
  localparam logic [GLB_W-1:0] RFC_LOAD = GLB_W'(T_RFC - 1);
  localparam logic [GLB_W-1:0] MRD_LOAD = GLB_W'(T_MRD - 1);
  localparam logic [REF_W-1:0] REF_DUE  = REF_W'(T_REF_MAX);
  localparam logic [REF_W-1:0] REF_SAT  = REF_W'(T_REF_MAX + 1);

  // Only the precharge-all bit of the address matters to the checker.
  logic addr_unused;
  assign addr_unused = ^{sdram_addr[12:11], sdram_addr[9:0]};

  cmd_e       cmd_s1_d, cmd_s1_q;
  logic [1:0] ba_s1_d, ba_s1_q;
  logic       a10_s1_d, a10_s1_q;
  logic       clr_s1_d, clr_s1_q;

  logic                  cmd_valid_d, cmd_valid_q;
  cmd_e                  cmd_code_d, cmd_code_q;
  logic [1:0]            cmd_ba_d, cmd_ba_q;
  logic [3:0]            bank_open_d, bank_open_q;
  logic [7:0]            err_flags_d, err_flags_q;
  logic                  err_pulse_d, err_pulse_q;
  logic [CNT_W-1:0]      aref_cnt_d, aref_cnt_q;
  logic [CNT_W-1:0]      rd_cnt_d, rd_cnt_q;
  logic [CNT_W-1:0]      wr_cnt_d, wr_cnt_q;
  logic [3:0][RCD_W-1:0] trcd_d, trcd_q;
  logic [3:0][RP_W-1:0]  trp_d, trp_q;
  logic [GLB_W-1:0]      glb_d, glb_q;
  logic                  glb_mrs_d, glb_mrs_q;
  logic [7:0]            viol;

  ref_state_e            ref_state_d, ref_state_q;
  logic [REF_W-1:0]      ref_cnt_d, ref_cnt_q;
  logic                  ref_overdue;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cmd_s1_d = CMD_NOP;
    if (!sdram_cs_n) begin
      case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
        3'b011:  cmd_s1_d = CMD_ACT;
        3'b101:  cmd_s1_d = CMD_RD;
        3'b100:  cmd_s1_d = CMD_WR;
        3'b010:  cmd_s1_d = CMD_PRE;
        3'b001:  cmd_s1_d = CMD_AREF;
        3'b000:  cmd_s1_d = CMD_MRS;
        3'b110:  cmd_s1_d = CMD_BST;
        default: cmd_s1_d = CMD_NOP;
      endcase
    end
    ba_s1_d  = sdram_ba;
    a10_s1_d = sdram_addr[10];
    clr_s1_d = err_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_s1_q <= CMD_NOP;
      ba_s1_q  <= '0;
      a10_s1_q <= 1'b0;
      clr_s1_q <= 1'b0;
    end else begin
      cmd_s1_q <= cmd_s1_d;
      ba_s1_q  <= ba_s1_d;
      a10_s1_q <= a10_s1_d;
      clr_s1_q <= clr_s1_d;
    end
  end

  // Refresh-interval watchdog: armed by the first AREF, fires once per late interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_state_q <= REF_IDLE;
      ref_cnt_q   <= '0;
    end else begin
      ref_state_q <= ref_state_d;
      ref_cnt_q   <= ref_cnt_d;
    end
  end

  always_comb begin
    ref_state_d = ref_state_q;
    ref_cnt_d   = ref_cnt_q;
    if (cmd_s1_q == CMD_AREF) begin
      ref_state_d = REF_ARMED;
      ref_cnt_d   = '0;
    end else if (ref_state_q == REF_ARMED && ref_cnt_q != REF_SAT) begin
      ref_cnt_d = ref_cnt_q + REF_W'(1);
    end
  end

  always_comb begin
    ref_overdue = (ref_state_q == REF_ARMED) && (ref_cnt_q == REF_DUE);
  end

  always_comb begin
    viol        = '0;
    cmd_valid_d = (cmd_s1_q != CMD_NOP);
    cmd_code_d  = cmd_s1_q;
    cmd_ba_d    = ba_s1_q;
    bank_open_d = bank_open_q;
    aref_cnt_d  = aref_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    glb_mrs_d   = glb_mrs_q;
    glb_d       = (glb_q == '0) ? glb_q : glb_q - GLB_W'(1);
    for (int unsigned b = 0; b < 4; b++) begin
      trcd_d[b] = (trcd_q[b] == '0) ? trcd_q[b] : trcd_q[b] - RCD_W'(1);
      trp_d[b]  = (trp_q[b] == '0) ? trp_q[b] : trp_q[b] - RP_W'(1);
    end

    // The shared AREF/MRS window reports against whichever command loaded it.
    if (cmd_valid_d && glb_q != '0) begin
      if (glb_mrs_q) viol[7] = 1'b1;
      else           viol[4] = 1'b1;
    end
    if (ref_overdue) viol[6] = 1'b1;

    case (cmd_s1_q)
      CMD_ACT: begin
        if (bank_open_q[ba_s1_q])   viol[0] = 1'b1;
        if (trp_q[ba_s1_q] != '0)   viol[3] = 1'b1;
        bank_open_d[ba_s1_q] = 1'b1;
        trcd_d[ba_s1_q]      = RCD_LOAD;
      end
      CMD_RD, CMD_WR: begin
        if (!bank_open_q[ba_s1_q])  viol[1] = 1'b1;
        if (trcd_q[ba_s1_q] != '0)  viol[2] = 1'b1;
        if (cmd_s1_q == CMD_RD) rd_cnt_d = sat_inc(rd_cnt_q);
        else                    wr_cnt_d = sat_inc(wr_cnt_q);
      end
      CMD_PRE: begin
        if (a10_s1_q) begin
          bank_open_d = '0;
          for (int unsigned b = 0; b < 4; b++) trp_d[b] = RP_LOAD;
        end else begin
          bank_open_d[ba_s1_q] = 1'b0;
          trp_d[ba_s1_q]       = RP_LOAD;
        end
      end
      CMD_AREF: begin
        if (|bank_open_q) viol[5] = 1'b1;
        glb_d      = RFC_LOAD;
        glb_mrs_d  = 1'b0;
        aref_cnt_d = sat_inc(aref_cnt_q);
      end
      CMD_MRS: begin
        if (|bank_open_q) viol[5] = 1'b1;
        glb_d     = MRD_LOAD;
        glb_mrs_d = 1'b1;
      end
      default: ;
    endcase

    err_flags_d = (clr_s1_q ? 8'h00 : err_flags_q) | viol;
    err_pulse_d = |viol;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NOP;
      cmd_ba_q    <= '0;
      bank_open_q <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
      aref_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      trcd_q      <= '0;
      trp_q       <= '0;
      glb_q       <= '0;
      glb_mrs_q   <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_ba_q    <= cmd_ba_d;
      bank_open_q <= bank_open_d;
      err_flags_q <= err_flags_d;
      err_pulse_q <= err_pulse_d;
      aref_cnt_q  <= aref_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      trcd_q      <= trcd_d;
      trp_q       <= trp_d;
      glb_q       <= glb_d;
      glb_mrs_q   <= glb_mrs_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_ba    = cmd_ba_q;
  assign bank_open = bank_open_q;
  assign err_flags = err_flags_q;
  assign err_pulse = err_pulse_q;
  assign aref_cnt  = aref_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Bench for sdram_cmd_monitor: directed scenarios plus random traffic, checked
// every cycle against a timestamp-based model of the command rules.
`timescale 1ns/1ps
module tb_sdram_cmd_monitor;

  localparam int T_RCD     = 2;
  localparam int T_RP      = 2;
  localparam int T_RFC     = 7;
  localparam int T_MRD     = 3;
  localparam int T_REF_MAX = 781;
  localparam int CNT_W     = 4;
  localparam int NEVER     = -1000000;

  localparam int NOP = 0, ACT = 1, RD = 2, WR = 3, PRE = 4, AREF = 5, MRS = 6, BST = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sdram_cs_n = 1'b1;
  logic             sdram_ras_n = 1'b1;
  logic             sdram_cas_n = 1'b1;
  logic             sdram_we_n = 1'b1;
  logic [1:0]       sdram_ba = '0;
  logic [12:0]      sdram_addr = '0;
  logic             err_clr = 1'b0;
  logic             cmd_valid;
  logic [2:0]       cmd_code;
  logic [1:0]       cmd_ba;
  logic [3:0]       bank_open;
  logic [7:0]       err_flags;
  logic             err_pulse;
  logic [CNT_W-1:0] aref_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;

  sdram_cmd_monitor #(
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
    .T_REF_MAX(T_REF_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .err_clr(err_clr),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ba(cmd_ba),
    .bank_open(bank_open), .err_flags(err_flags), .err_pulse(err_pulse),
    .aref_cnt(aref_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             valid;
    logic [2:0]       code;
    logic [1:0]       ba;
    logic [3:0]       open;
    logic [7:0]       flags;
    logic             pulse;
    logic [CNT_W-1:0] aref;
    logic [CNT_W-1:0] rd;
    logic [CNT_W-1:0] wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Model: event timestamps instead of down-counters.
  int       t;
  bit [3:0] m_open;
  bit [7:0] m_flags;
  int       m_aref, m_rd, m_wr;
  int       last_act[4];
  int       last_pre[4];
  int       last_glb;
  bit       glb_mrs;
  bit       armed;
  int       last_aref;

  function automatic int sat(input int v);
    return (v > (2**CNT_W) - 1) ? (2**CNT_W) - 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_open = '0; m_flags = '0; m_aref = 0; m_rd = 0; m_wr = 0;
    for (int i = 0; i < 4; i++) begin
      last_act[i] = NEVER;
      last_pre[i] = NEVER;
    end
    last_glb = NEVER; glb_mrs = 1'b0; armed = 1'b0; last_aref = NEVER;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic model_step(input int code, input logic [1:0] b, input bit a10, input bit clr);
    bit [7:0] v;
    exp_t     e;
    v = '0;
    if (code != NOP && (t - last_glb) < (glb_mrs ? T_MRD : T_RFC)) begin
      if (glb_mrs) v[7] = 1'b1;
      else         v[4] = 1'b1;
    end
    if (armed && (t - last_aref) == T_REF_MAX + 1) v[6] = 1'b1;
    case (code)
      ACT: begin
        if (m_open[b]) v[0] = 1'b1;
        if ((t - last_pre[b]) < T_RP) v[3] = 1'b1;
        m_open[b] = 1'b1;
        last_act[b] = t;
      end
      RD, WR: begin
        if (!m_open[b]) v[1] = 1'b1;
        if ((t - last_act[b]) < T_RCD) v[2] = 1'b1;
        if (code == RD) m_rd = sat(m_rd + 1);
        else            m_wr = sat(m_wr + 1);
      end
      PRE: begin
        if (a10) begin
          m_open = '0;
          for (int i = 0; i < 4; i++) last_pre[i] = t;
        end else begin
          m_open[b] = 1'b0;
          last_pre[b] = t;
        end
      end
      AREF: begin
        if (m_open != 0) v[5] = 1'b1;
        last_glb = t; glb_mrs = 1'b0; armed = 1'b1; last_aref = t;
        m_aref = sat(m_aref + 1);
      end
      MRS: begin
        if (m_open != 0) v[5] = 1'b1;
        last_glb = t; glb_mrs = 1'b1;
      end
      default: ;
    endcase
    m_flags = (clr ? 8'h00 : m_flags) | v;
    e.valid = (code != NOP);
    e.code  = 3'(code);
    e.ba    = b;
    e.open  = m_open;
    e.flags = m_flags;
    e.pulse = |v;
    e.aref  = CNT_W'(m_aref);
    e.rd    = CNT_W'(m_rd);
    e.wr    = CNT_W'(m_wr);
    exp_q.push_back(e);
    t++;
  endtask

  task automatic drive(input int code, input logic [1:0] b, input bit a10, input bit clr);
    logic [3:0]  p;
    logic [12:0] a;
    case (code)
      ACT:     p = 4'b0011;
      RD:      p = 4'b0101;
      WR:      p = 4'b0100;
      PRE:     p = 4'b0010;
      AREF:    p = 4'b0001;
      MRS:     p = 4'b0000;
      BST:     p = 4'b0110;
      default: p = ($urandom_range(0, 1) == 1) ? {1'b1, 3'($urandom_range(0, 7))} : 4'b0111;
    endcase
    a = 13'($urandom);
    a[10] = a10;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = p;
    sdram_ba   = b;
    sdram_addr = a;
    err_clr    = clr;
  endtask

  task automatic check_exp(input exp_t e);
    chk("cmd_valid", 32'(cmd_valid), 32'(e.valid));
    chk("cmd_code",  32'(cmd_code),  32'(e.code));
    chk("cmd_ba",    32'(cmd_ba),    32'(e.ba));
    chk("bank_open", 32'(bank_open), 32'(e.open));
    chk("err_flags", 32'(err_flags), 32'(e.flags));
    chk("err_pulse", 32'(err_pulse), 32'(e.pulse));
    chk("aref_cnt",  32'(aref_cnt),  32'(e.aref));
    chk("rd_cnt",    32'(rd_cnt),    32'(e.rd));
    chk("wr_cnt",    32'(wr_cnt),    32'(e.wr));
  endtask

  // Drive one command, advance one clock; outputs then reflect the previous command.
  task automatic cycle(input int code, input logic [1:0] b, input bit a10, input bit clr);
    drive(code, b, a10, clr);
    model_step(code, b, a10, clr);
    @(negedge clk);
    if (exp_q.size() >= 2) check_exp(exp_q.pop_front());
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cycle(NOP, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_code"},  32'(cmd_code),  32'd0);
    chk({tag, "_ba"},    32'(cmd_ba),    32'd0);
    chk({tag, "_open"},  32'(bank_open), 32'd0);
    chk({tag, "_flags"}, 32'(err_flags), 32'd0);
    chk({tag, "_pulse"}, 32'(err_pulse), 32'd0);
    chk({tag, "_aref"},  32'(aref_cnt),  32'd0);
    chk({tag, "_rd"},    32'(rd_cnt),    32'd0);
    chk({tag, "_wr"},    32'(wr_cnt),    32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(NOP, 2'd0, 1'b0, 1'b0);
    #1;
    check_zero({tag, "_async"});
    @(negedge clk);
    check_zero({tag, "_next"});
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int pulses;
    int r;
    int code;
    #2;
    do_reset("rst0");

    // Legal init sequence.
    cycle(MRS, 2'd0, 1'b0, 1'b0);
    nops(3);
    cycle(AREF, 2'd0, 1'b0, 1'b0);
    nops(7);
    cycle(ACT, 2'd0, 1'b0, 1'b0);
    nops(1);
    cycle(WR, 2'd0, 1'b0, 1'b0);
    nops(5);
    cycle(PRE, 2'd0, 1'b0, 1'b0);
    nops(1);
    chk("t1_err_flags", 32'(err_flags), 32'h00);
    chk("t1_wr_cnt",    32'(wr_cnt),    32'd1);
    chk("t1_aref_cnt",  32'(aref_cnt),  32'd1);
    chk("t1_bank_open", 32'(bank_open), 32'h0);

    // tRCD violation.
    do_reset("rst2");
    cycle(ACT, 2'd1, 1'b0, 1'b0);
    cycle(RD, 2'd1, 1'b0, 1'b0);
    nops(1);
    chk("t2_err_flags", 32'(err_flags), 32'h04);
    chk("t2_err_pulse", 32'(err_pulse), 32'd1);
    chk("t2_rd_cnt",    32'(rd_cnt),    32'd1);

    // AREF with open bank, precharge-all, then tRP violation.
    do_reset("rst3");
    cycle(ACT, 2'd2, 1'b0, 1'b0);
    nops(1);
    cycle(AREF, 2'd0, 1'b0, 1'b0);
    nops(1);
    chk("t3_aref_open", 32'(err_flags), 32'h20);
    nops(5);
    cycle(PRE, 2'd1, 1'b1, 1'b0);
    cycle(ACT, 2'd3, 1'b0, 1'b0);
    chk("t3_pre_all", 32'(bank_open), 32'h0);
    nops(1);
    chk("t3_trp_flags", 32'(err_flags), 32'h28);
    chk("t3_bank_open", 32'(bank_open), 32'h8);

    // tRFC violation, then overdue refresh.
    do_reset("rst4");
    cycle(AREF, 2'd0, 1'b0, 1'b0);
    nops(4);
    cycle(ACT, 2'd0, 1'b0, 1'b0);
    nops(1);
    chk("t4_trfc_flags", 32'(err_flags), 32'h10);
    chk("t4_trfc_pulse", 32'(err_pulse), 32'd1);
    pulses = 0;
    for (int s = 7; s <= 900; s++) begin
      cycle(NOP, 2'd0, 1'b0, 1'b0);
      pulses += int'(err_pulse);
    end
    chk("t4_ref_pulses", 32'(pulses), 32'd1);
    chk("t4_ref_flags",  32'(err_flags), 32'h50);

    // err_clr coinciding with a new violation.
    do_reset("rst5");
    cycle(RD, 2'd0, 1'b0, 1'b0);
    cycle(ACT, 2'd1, 1'b0, 1'b0);
    cycle(ACT, 2'd1, 1'b0, 1'b0);
    nops(1);
    chk("t5_pre_clr", 32'(err_flags), 32'h03);
    cycle(RD, 2'd0, 1'b0, 1'b1);
    nops(1);
    chk("t5_post_clr", 32'(err_flags), 32'h02);

    // Counter saturation.
    do_reset("rst_sat");
    for (int i = 0; i < 18; i++) begin
      cycle(RD, 2'd0, 1'b0, 1'b0);
      cycle(WR, 2'd1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 18; i++) begin
      cycle(AREF, 2'd0, 1'b0, 1'b0);
      nops(6);
    end
    nops(1);
    chk("sat_rd_cnt",   32'(rd_cnt),   32'hF);
    chk("sat_wr_cnt",   32'(wr_cnt),   32'hF);
    chk("sat_aref_cnt", 32'(aref_cnt), 32'hF);

    // Reset mid-burst disarms the refresh watchdog.
    do_reset("rst6a");
    cycle(AREF, 2'd0, 1'b0, 1'b0);
    nops(7);
    for (int i = 0; i < 40; i++)
      cycle($urandom_range(ACT, PRE), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    nops(350);
    do_reset("rst6b");
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      cycle(NOP, 2'd0, 1'b0, 1'b0);
      pulses += int'(err_pulse);
    end
    chk("t6_no_ref_pulse", 32'(pulses), 32'd0);
    chk("t6_flags",        32'(err_flags), 32'h00);

    // Random traffic.
    do_reset("rst_rnd");
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset("rst_mid");
      r = $urandom_range(0, 31);
      if      (r < 4)   code = ACT;
      else if (r < 7)   code = RD;
      else if (r < 10)  code = WR;
      else if (r < 13)  code = PRE;
      else if (r == 13) code = AREF;
      else if (r == 14) code = MRS;
      else if (r == 15) code = BST;
      else              code = NOP;
      cycle(code, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0));
    end
    nops(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
